// File: rtl/ps2_pkg.sv
// ps2_pkg -- definitions shared by the PS/2 receive path and the future
// PS/2 transmitter.
//   * state encoding of the frame FSM (IDLE=0, DATA=1, PARITY=2, STOP=3)
//   * frame length in bits (start + 8 data + parity + stop)
//   * odd-parity helper
package ps2_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } ps2_state_t;

    localparam int FRAME_BITS = 11;

    // Parity bit that makes (data ones + parity bit) odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock show-ahead FIFO, shared with the UART path.
// Ports:
//   clk100, rst_n : clock, synchronous active-low reset
//   push, din     : write request and data; accepted when not full, or when
//                   full and a pop happens in the same cycle
//   pop           : remove head; ignored when empty
//   dout          : head entry, reads 0 when empty
//   count         : entries queued; full / empty flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk100,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot the simultaneous push needs.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; only written entries are
    // ever read and dout is masked to 0 while empty.
    always_ff @(posedge clk100) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo -- PS/2 device-to-host receiver with clock-edge filter,
// odd-parity / stop-bit checks, frame timeout and a buffered output queue.
// Ports:
//   clk100, rst_n       : system clock, synchronous active-low reset
//   ps2_clk, ps2_data   : asynchronous PS/2 pins
//   rx_data, rx_valid   : queue head byte (0 when empty) and not-empty flag
//   rx_ready            : consumer accepts the head byte
//   err_parity          : 1-cycle pulse, frame dropped for bad parity
//   err_frame           : 1-cycle pulse, frame dropped for bad stop / timeout
//   err_overflow        : 1-cycle pulse, good byte dropped, queue full
//   fifo_count          : entries queued
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                              clk100,
    input  logic                              rst_n,
    input  logic                              ps2_clk,
    input  logic                              ps2_data,
    output logic [7:0]                        rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic                              err_parity,
    output logic                              err_frame,
    output logic                              err_overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int HALF = FILTER_LEN / 2;
    // Oldest half high, newest half low: a clean, settled falling edge.
    localparam logic [FILTER_LEN-1:0] EDGE_PAT = {{HALF{1'b1}}, {HALF{1'b0}}};
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]            clk_sync;
    logic [1:0]            data_sync;
    logic [FILTER_LEN-1:0] hist;
    logic                  fall;
    logic                  bit_in;

    ps2_state_t            state, state_nxt;
    logic [2:0]            bit_cnt, bit_cnt_nxt;
    logic [7:0]            shift, shift_nxt;
    logic                  par_bit, par_bit_nxt;
    logic [TO_W-1:0]       to_cnt, to_cnt_nxt;
    logic                  push;
    logic                  perr_nxt;
    logic                  ferr_nxt;

    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Synchronisers and clock history idle high, like the bus.
    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            hist      <= '1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            hist      <= {hist[FILTER_LEN-2:0], clk_sync[1]};
        end
    end

    assign fall   = (hist == EDGE_PAT);
    assign bit_in = data_sync[1];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        par_bit_nxt = par_bit;
        to_cnt_nxt  = to_cnt + 1'b1;
        push        = 1'b0;
        perr_nxt    = 1'b0;
        ferr_nxt    = 1'b0;

        if (fall) begin
            // An edge always beats a coincident timeout.
            to_cnt_nxt = '0;
            case (state)
                IDLE: begin
                    if (!bit_in) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    shift_nxt   = {bit_in, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    par_bit_nxt = bit_in;
                    state_nxt   = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    // A bad stop bit dominates whatever the parity says.
                    if (!bit_in)                         ferr_nxt = 1'b1;
                    else if (par_bit == odd_parity(shift)) push   = 1'b1;
                    else                                 perr_nxt = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && to_cnt == TO_LAST) begin
            state_nxt  = IDLE;
            ferr_nxt   = 1'b1;
            to_cnt_nxt = '0;
        end

        if (state == IDLE) to_cnt_nxt = '0;
    end

    assign rx_valid = !fifo_empty;
    assign pop      = rx_valid && rx_ready;

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            par_bit      <= 1'b0;
            to_cnt       <= '0;
            err_parity   <= 1'b0;
            err_frame    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            shift        <= shift_nxt;
            par_bit      <= par_bit_nxt;
            to_cnt       <= to_cnt_nxt;
            err_parity   <= perr_nxt;
            err_frame    <= ferr_nxt;
            // A pop in the same cycle makes room, so only a stalled full
            // queue drops the byte.
            err_overflow <= push && fifo_full && !pop;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk100 (clk100),
        .rst_n  (rst_n),
        .push   (push),
        .din    (shift),
        .pop    (pop),
        .dout   (rx_data),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo -- self-checking bench for ps2_rx_fifo.
// Frames are bit-banged on ps2_clk/ps2_data at a shortened bit period; good
// bytes are pushed to an expected queue when sent, a monitor logs every
// handshake transfer, and each scenario task compares the two queues plus
// the error-pulse counts.
module tb_ps2_rx_fifo;

    localparam int FILTER_LEN     = 4;
    localparam int FIFO_DEPTH     = 16;
    localparam int TIMEOUT_CYCLES = 600;
    localparam int CW             = $clog2(FIFO_DEPTH + 1);
    localparam int HB             = 20;   // half PS/2 bit period, cycles
    localparam int GAP            = 30;   // idle cycles after each frame
    localparam int LATENCY        = FILTER_LEN / 2 + 3;

    logic          clk100   = 1'b0;
    logic          rst_n    = 1'b0;
    logic          ps2_clk  = 1'b1;
    logic          ps2_data = 1'b1;
    logic          rx_ready = 1'b0;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          err_parity;
    logic          err_frame;
    logic          err_overflow;
    logic [CW-1:0] fifo_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_rd = 0;
    logic [7:0] exp_b;

    int cyc            = 0;
    int stop_fall_cyc  = 0;
    int valid_rise_cyc = -1;
    int valid_cycles   = 0;
    int n_perr = 0, n_ferr = 0, n_ovf = 0;
    int viol_width = 0, viol_empty = 0, viol_stall = 0;

    logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b0;
    logic       prev_perr = 1'b0, prev_ferr = 1'b0, prev_ovf = 1'b0;
    logic [7:0] prev_data = 8'h00;

    ps2_rx_fifo #(
        .FILTER_LEN     (FILTER_LEN),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk100       (clk100),
        .rst_n        (rst_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .err_parity   (err_parity),
        .err_frame    (err_frame),
        .err_overflow (err_overflow),
        .fifo_count   (fifo_count)
    );

    always #5 clk100 = ~clk100;

    always @(posedge clk100) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, away from DUT updates.
    always @(negedge clk100) begin
        if (rst_n && rx_valid && rx_ready) got_q.push_back(rx_data);
        if (rx_valid === 1'b1 && !prev_valid) valid_rise_cyc = cyc;
        if (rx_valid === 1'b1) valid_cycles++;
        if (err_parity === 1'b1)   n_perr++;
        if (err_frame === 1'b1)    n_ferr++;
        if (err_overflow === 1'b1) n_ovf++;
        if ((err_parity === 1'b1 && prev_perr) || (err_frame === 1'b1 && prev_ferr) ||
            (err_overflow === 1'b1 && prev_ovf))
            viol_width++;
        if (rst_n && prev_rst && rx_valid === 1'b0 && rx_data !== 8'h00) viol_empty++;
        if (prev_rst && prev_valid && !prev_ready && (rx_valid !== 1'b1 || rx_data !== prev_data))
            viol_stall++;
        prev_valid = (rx_valid === 1'b1);
        prev_ready = rx_ready;
        prev_rst   = rst_n;
        prev_data  = rx_data;
        prev_perr  = (err_parity === 1'b1);
        prev_ferr  = (err_frame === 1'b1);
        prev_ovf   = (err_overflow === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk100);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HB);
        ps2_clk = 1'b0;
        tick(HB);
        ps2_clk = 1'b1;
    endtask

    // ready_pulse raises rx_ready for exactly the cycle in which the stop
    // bit is recognised, so a push and a pop coincide.
    task automatic send_frame(input logic [7:0] d, input logic bad_par,
                              input logic stop_bit, input logic ready_pulse);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_data = stop_bit;
        tick(HB);
        ps2_clk = 1'b0;
        stop_fall_cyc = cyc;
        if (ready_pulse) begin
            tick(LATENCY - 1);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
            tick(HB - LATENCY);
        end else begin
            tick(HB);
        end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(GAP);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        vectors++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 || fifo_count !== '0 ||
            err_parity !== 1'b0 || err_frame !== 1'b0 || err_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b data=%h count=%0d errs=%b%b%b, required all 0",
                     rx_valid, rx_data, fifo_count, err_parity, err_frame, err_overflow);
        end
        rst_n = 1'b1;
        tick(10);
    endtask

    task automatic test_good_frame();
        int b_p, b_f, b_o, b_v;
        b_p = n_perr; b_f = n_ferr; b_o = n_ovf; b_v = valid_cycles;
        rx_ready = 1'b1;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(8'h1C);
        vectors++;
        if (valid_rise_cyc - stop_fall_cyc != LATENCY) begin
            miscompares++;
            $display("FAIL good_latency: got %0d cycles, required %0d",
                     valid_rise_cyc - stop_fall_cyc, LATENCY);
        end
        vectors++;
        if (valid_cycles - b_v != 1) begin
            miscompares++;
            $display("FAIL good_valid_cycles: got %0d, required 1", valid_cycles - b_v);
        end
        vectors++;
        if (n_perr != b_p || n_ferr != b_f || n_ovf != b_o) begin
            miscompares++;
            $display("FAIL good_errors: perr=%0d ferr=%0d ovf=%0d pulses, required 0",
                     n_perr - b_p, n_ferr - b_f, n_ovf - b_o);
        end
        vectors++;
        if (fifo_count !== '0) begin
            miscompares++;
            $display("FAIL good_count: got %0d, required 0", fifo_count);
        end
        while (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            vectors++;
            if (got_rd >= got_q.size()) begin
                miscompares++;
                $display("FAIL good_byte: got none, required %h", exp_b);
            end else begin
                if (got_q[got_rd] !== exp_b) begin
                    miscompares++;
                    $display("FAIL good_byte: got %h, required %h", got_q[got_rd], exp_b);
                end
                got_rd++;
            end
        end
    endtask

    task automatic test_bad_parity();
        int b_p, b_f;
        b_p = n_perr; b_f = n_ferr;
        rx_ready = 1'b1;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (n_perr - b_p != 1 || n_ferr != b_f) begin
            miscompares++;
            $display("FAIL parity_pulses: perr=%0d ferr=%0d, required perr=1 ferr=0",
                     n_perr - b_p, n_ferr - b_f);
        end
        vectors++;
        if (got_q.size() != got_rd || fifo_count !== '0) begin
            miscompares++;
            $display("FAIL parity_dropped: %0d bytes out, count=%0d, required 0/0",
                     got_q.size() - got_rd, fifo_count);
            got_rd = got_q.size();
        end
    endtask

    task automatic test_bad_stop();
        int b_p, b_f;
        rx_ready = 1'b1;
        for (int bp = 0; bp < 2; bp++) begin
            b_p = n_perr; b_f = n_ferr;
            send_frame(8'h1C, bp[0], 1'b0, 1'b0);
            vectors++;
            if (n_ferr - b_f != 1 || n_perr != b_p) begin
                miscompares++;
                $display("FAIL stop_pulses(badpar=%0d): ferr=%0d perr=%0d, required ferr=1 perr=0",
                         bp, n_ferr - b_f, n_perr - b_p);
            end
        end
        vectors++;
        if (got_q.size() != got_rd || fifo_count !== '0) begin
            miscompares++;
            $display("FAIL stop_dropped: %0d bytes out, count=%0d, required 0/0",
                     got_q.size() - got_rd, fifo_count);
            got_rd = got_q.size();
        end
    endtask

    // A 1-cycle low with data low would look like a start bit if accepted;
    // the following frame would then be misaligned.
    task automatic test_glitch();
        int b_p, b_f;
        b_p = n_perr; b_f = n_ferr;
        rx_ready = 1'b1;
        ps2_data = 1'b0;
        tick(HB);
        ps2_clk = 1'b0;
        tick(1);
        ps2_clk = 1'b1;
        tick(HB);
        ps2_data = 1'b1;
        tick(GAP);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(8'hA5);
        vectors++;
        if (n_perr != b_p || n_ferr != b_f) begin
            miscompares++;
            $display("FAIL glitch_errors: perr=%0d ferr=%0d, required 0/0", n_perr - b_p, n_ferr - b_f);
        end
        while (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            vectors++;
            if (got_rd >= got_q.size()) begin
                miscompares++;
                $display("FAIL glitch_byte: got none, required %h", exp_b);
            end else begin
                if (got_q[got_rd] !== exp_b) begin
                    miscompares++;
                    $display("FAIL glitch_byte: got %h, required %h", got_q[got_rd], exp_b);
                end
                got_rd++;
            end
        end
    endtask

    task automatic test_timeout();
        int b_f;
        b_f = n_ferr;
        rx_ready = 1'b1;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        ps2_data = 1'b1;
        tick(TIMEOUT_CYCLES - 100);
        vectors++;
        if (n_ferr != b_f) begin
            miscompares++;
            $display("FAIL timeout_early: ferr=%0d before limit, required 0", n_ferr - b_f);
        end
        tick(200);
        vectors++;
        if (n_ferr - b_f != 1) begin
            miscompares++;
            $display("FAIL timeout_pulse: ferr=%0d, required 1", n_ferr - b_f);
        end
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(8'hF0);
        vectors++;
        if (n_ferr - b_f != 1 || fifo_count !== '0) begin
            miscompares++;
            $display("FAIL timeout_recover: ferr=%0d count=%0d, required 1/0", n_ferr - b_f, fifo_count);
        end
        while (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            vectors++;
            if (got_rd >= got_q.size()) begin
                miscompares++;
                $display("FAIL timeout_byte: got none, required %h", exp_b);
            end else begin
                if (got_q[got_rd] !== exp_b) begin
                    miscompares++;
                    $display("FAIL timeout_byte: got %h, required %h", got_q[got_rd], exp_b);
                end
                got_rd++;
            end
        end
    endtask

    task automatic test_overflow();
        int b_o;
        b_o = n_ovf;
        rx_ready = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            send_frame(8'(i), 1'b0, 1'b1, 1'b0);
            exp_q.push_back(8'(i));
        end
        vectors++;
        if (fifo_count !== CW'(FIFO_DEPTH) || n_ovf != b_o) begin
            miscompares++;
            $display("FAIL fill: count=%0d ovf=%0d, required %0d/0", fifo_count, n_ovf - b_o, FIFO_DEPTH);
        end
        send_frame(8'(FIFO_DEPTH), 1'b0, 1'b1, 1'b0);
        vectors++;
        if (fifo_count !== CW'(FIFO_DEPTH) || n_ovf - b_o != 1) begin
            miscompares++;
            $display("FAIL overflow: count=%0d ovf=%0d, required %0d/1", fifo_count, n_ovf - b_o, FIFO_DEPTH);
        end
        // Full queue, push and pop land in the same cycle: accepted, no overflow.
        send_frame(8'h77, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(8'h77);
        vectors++;
        if (fifo_count !== CW'(FIFO_DEPTH) || n_ovf - b_o != 1) begin
            miscompares++;
            $display("FAIL full_push_pop: count=%0d ovf=%0d, required %0d/1", fifo_count, n_ovf - b_o, FIFO_DEPTH);
        end
        rx_ready = 1'b1;
        tick(2 * FIFO_DEPTH + 10);
        vectors++;
        if (fifo_count !== '0) begin
            miscompares++;
            $display("FAIL drain_count: got %0d, required 0", fifo_count);
        end
        while (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            vectors++;
            if (got_rd >= got_q.size()) begin
                miscompares++;
                $display("FAIL drain_byte: got none, required %h", exp_b);
            end else begin
                if (got_q[got_rd] !== exp_b) begin
                    miscompares++;
                    $display("FAIL drain_byte: got %h, required %h", got_q[got_rd], exp_b);
                end
                got_rd++;
            end
        end
        vectors++;
        if (got_q.size() != got_rd) begin
            miscompares++;
            $display("FAIL drain_extra: %0d unexpected bytes, required 0", got_q.size() - got_rd);
            got_rd = got_q.size();
        end
    endtask

    task automatic test_reset_midframe();
        int b_p, b_f;
        rx_ready = 1'b0;
        send_frame(8'h33, 1'b0, 1'b1, 1'b0);   // queued, then wiped by reset
        vectors++;
        if (fifo_count !== CW'(1) || rx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_queue: count=%0d valid=%b, required 1/1", fifo_count, rx_valid);
        end
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        rst_n = 1'b0;
        tick(1);
        vectors++;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 || fifo_count !== '0 ||
            err_parity !== 1'b0 || err_frame !== 1'b0 || err_overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_reset_outputs: valid=%b data=%h count=%0d errs=%b%b%b, required all 0",
                     rx_valid, rx_data, fifo_count, err_parity, err_frame, err_overflow);
        end
        rst_n = 1'b1;
        tick(GAP);
        b_p = n_perr; b_f = n_ferr;
        rx_ready = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(8'h5A);
        tick(TIMEOUT_CYCLES);
        vectors++;
        if (n_perr != b_p || n_ferr != b_f || fifo_count !== '0) begin
            miscompares++;
            $display("FAIL post_reset_frame: perr=%0d ferr=%0d count=%0d, required 0/0/0",
                     n_perr - b_p, n_ferr - b_f, fifo_count);
        end
        while (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            vectors++;
            if (got_rd >= got_q.size()) begin
                miscompares++;
                $display("FAIL post_reset_byte: got none, required %h", exp_b);
            end else begin
                if (got_q[got_rd] !== exp_b) begin
                    miscompares++;
                    $display("FAIL post_reset_byte: got %h, required %h", got_q[got_rd], exp_b);
                end
                got_rd++;
            end
        end
        vectors++;
        if (got_q.size() != got_rd) begin
            miscompares++;
            $display("FAIL post_reset_extra: %0d unexpected bytes, required 0", got_q.size() - got_rd);
        end
    endtask

    task automatic test_protocol();
        vectors++;
        if (viol_width != 0) begin
            miscompares++;
            $display("FAIL pulse_width: %0d multi-cycle pulses, required 0", viol_width);
        end
        vectors++;
        if (viol_empty != 0) begin
            miscompares++;
            $display("FAIL empty_data_zero: %0d cycles nonzero, required 0", viol_empty);
        end
        vectors++;
        if (viol_stall != 0) begin
            miscompares++;
            $display("FAIL stall_stable: %0d unstable cycles, required 0", viol_stall);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_bad_stop();
        test_glitch();
        test_timeout();
        test_overflow();
        test_reset_midframe();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
